// File: rtl/prio_req_scheduler_pkg.sv
// Shared types and helpers for the priority request scheduler.
package prio_req_scheduler_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef logic [NREQ-1:0]  req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_vec_t onehot(input idx_t i);
    return req_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/prio_req_scheduler_enco.sv
// Combinational 8-input priority encoder, bit 0 highest priority.
// Output is meaningless for an all-zero input; callers must qualify it.
module eight_bit_prio_enco
  import prio_req_scheduler_pkg::*;
(
  input  req_vec_t req,
  output idx_t     idx
);

  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) idx = idx_t'(i);
    end
  end

endmodule

// File: rtl/prio_req_scheduler.sv
// Captures request pulses, grants the lowest pending index over valid/ready; 1-cycle latency.
// Output index is frozen while stalled; new requests keep accumulating in pending.
module prio_req_scheduler #(
  parameter int NREQ  = 8,
  parameter int CNT_W = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NREQ-1:0]                          req_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [prio_req_scheduler_pkg::IDX_W-1:0] out_idx,
  output logic [NREQ-1:0]                          pending,
  output logic                                     dup_err,
  output logic [CNT_W-1:0]                         grant_cnt
);

  import prio_req_scheduler_pkg::*;

  logic     fire;
  logic     load;
  logic     cand_nz;
  req_vec_t cand;
  req_vec_t held_vec;
  idx_t     sel;

  assign fire    = out_valid & out_ready;
  assign load    = ~out_valid | out_ready;
  assign cand    = pending | req_in;
  assign cand_nz = |cand;

  // A request is a duplicate only while its index sits stalled in the output stage.
  assign held_vec = {NREQ{out_valid & ~out_ready}} & onehot(out_idx);

  eight_bit_prio_enco u_enco (
    .req (cand),
    .idx (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      dup_err   <= 1'b0;
      grant_cnt <= '0;
    end else begin
      dup_err <= |(req_in & (pending | held_vec));
      if (fire) grant_cnt <= grant_cnt + 1'b1;
      if (load) begin
        // sel is only trusted when cand is non-zero
        if (cand_nz) begin
          out_valid <= 1'b1;
          out_idx   <= sel;
          pending   <= cand & ~onehot(sel);
        end else begin
          out_valid <= 1'b0;
          pending   <= '0;
        end
      end else begin
        pending <= cand;
      end
    end
  end

endmodule

// File: doc/prio_req_scheduler.md
Name: prio_req_scheduler

Overview:
- Sequential front end for the 8-input LSB-first priority encoder (bit 0 = highest priority).
- Captures single-cycle request pulses into a pending register and selects the lowest pending index.
- Issues one index at a time to a downstream consumer over a valid/ready handshake, then clears the served request.
- Reports duplicate requests and keeps a running grant count.

Parameters:
- NREQ, 8: number of request lines. Only 8 is supported; this matches the 3-bit index.
- CNT_W, 8: width of the grant counter.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_in  in  8  request pulses; bit i high for one cycle = one request on line i
- out_valid  out  1  out_idx holds a granted index
- out_ready  in  1  consumer accepts out_idx this cycle
- out_idx  out  3  granted index, 0..7
- pending  out  8  requests not yet loaded into the output stage
- dup_err  out  1  one-cycle pulse: a request arrived for a line already outstanding
- grant_cnt  out  CNT_W  number of completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, released on a clock edge): pending=0, out_valid=0, out_idx=0, dup_err=0, grant_cnt=0. Reset mid-handshake discards all pending and held requests; no grant is counted.
- Definitions:
  - fire = out_valid & out_ready.
  - load = !out_valid | out_ready (output stage empty or being drained).
  - cand = pending | req_in.
  - sel = lowest set index of cand; onehot(sel) = 1<<sel.
- Each rising edge:
  - If load and cand != 0: out_valid<=1, out_idx<=sel, pending<=cand & ~onehot(sel).
  - If load and cand == 0: out_valid<=0, out_idx holds its old value, pending<=0.
  - If !load: out_valid and out_idx hold, pending<=cand.
- Latency: a request on an idle block appears as out_valid in the next cycle (1 cycle). Back-to-back grants are possible every cycle while out_ready=1.
- Stability: while out_valid & !out_ready, out_idx must not change, even if a higher-priority request arrives.
- Priority: strict, index 0 highest. Starvation of high indices is permitted and documented; no fairness logic.
- Duplicates:
  - dup_err<=1 for the cycle after req_in[i] & (pending[i] | (out_valid & !out_ready & out_idx==i)). It is 0 otherwise.
  - A duplicate merges into the existing request; it is not counted twice.
  - req_in[i] in the same cycle that index i fires is a new request, not a duplicate.
- grant_cnt increments by 1 on every fire and wraps from 2^CNT_W-1 to 0.
- All 8 lines pending: served as 0,1,...,7 on consecutive ready cycles.

Decomposition:
- Shared package holds:
  - constant NREQ=8, IDX_W=3
  - typedef req_vec_t (8 bits), idx_t (3 bits)
  - function onehot(idx_t) returning req_vec_t
- One sub-module: the existing combinational eight_bit_prio_enco, instantiated unchanged on cand to produce sel.
- cand==0 is detected separately because the encoder output is don't-care (x) for an all-zero input; sel must never be used when cand==0.

Test Plan:
- Reset with req_in=8'hFF held → outputs stay at reset values; after release, out_valid=1, out_idx=0 next cycle, pending=8'hFE.
- req_in=8'b1010_0100 for one cycle, out_ready=1 → out_idx sequence 2,5,7 on consecutive cycles, then out_valid=0; grant_cnt=3.
- Stall: out_idx=5 held with out_ready=0, then req_in=8'h01 → out_idx stays 5 and pending=8'h01; when out_ready=1, the next grant is 0.
- Duplicate: line 3 pending and req_in[3]=1 again → dup_err=1 for one cycle; line 3 is granted exactly once.
- Same-cycle re-request: out_idx=4 fires while req_in[4]=1 → dup_err=0 and 4 is granted again later; grant_cnt counts both.
- Wrap and reset: 256 grants → grant_cnt=0; assert rst while out_valid=1 and pending=8'h0C → all outputs clear immediately, asynchronously.
